// File: rtl/jtframe_debug_viewsel_pkg.sv
// jtframe_debug_viewsel_pkg
// Shared definitions for the debug view selector: FSM state encoding, search
// direction, the largest supported source count and the index stepping helper
// used while walking candidates.
package jtframe_debug_viewsel_pkg;

  // Upper bound on the number of selectable debug sources.
  localparam int MAX_NSRC = 8;

  // Bit positions inside the edge-detector bank.
  localparam int EV_NEXT   = 0;
  localparam int EV_PREV   = 1;
  localparam int EV_AUTO   = 2;
  localparam int EV_FREEZE = 3;
  localparam int EV_LVBL   = 4;
  localparam int EV_W      = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Step an index one place in direction d, wrapping explicitly at last so
  // non-power-of-2 source counts work.
  function automatic logic [2:0] step_idx(input logic [2:0] v, input dir_t d,
                                          input logic [2:0] last);
    if (d == DIR_UP) return (v == last) ? 3'd0 : v + 3'd1;
    else             return (v == 3'd0) ? last : v - 3'd1;
  endfunction

endpackage

// File: rtl/jtframe_debug_edge.sv
// jtframe_debug_edge
// Bank of W single-register edge detectors. Each bit reports a rising edge
// (din & ~din_l) unless its FALL_MASK bit is set, in which case it reports a
// falling edge (~din & din_l). History registers clear to 0 on reset.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   din    level inputs
//   ev     one-cycle edge events, combinational from din and its history
module jtframe_debug_edge #(
  parameter int             W         = 1,
  parameter logic [W-1:0]   FALL_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] ev
);

  logic [W-1:0] din_l;

  always_ff @(posedge clk) begin
    if (!rst_n) din_l <= '0;
    else        din_l <= din;
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      if (FALL_MASK[gi]) begin : g_fall
        assign ev[gi] = ~din[gi] & din_l[gi];
      end else begin : g_rise
        assign ev[gi] = din[gi] & ~din_l[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/jtframe_debug_viewsel.sv
// jtframe_debug_viewsel
// Chooses which core debug register drives the overlay value. Manual next/prev
// keys or a frame-timed auto scan start a search that skips sources whose
// src_req is low. The chosen source is sampled once per frame at the start of
// vertical blank so the overlay value never changes mid-frame.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   lvbl                vertical blank (low during blank); its fall is the frame tick
//   key_next/prev       level keys stepping the selection up/down
//   key_auto/freeze     level keys toggling auto scan / freezing view_data
//   src_req, src_data   per-source display request and 8-bit value
//   view_sel            selected source index
//   view_data           value latched from the selected source
//   view_valid          a latch has happened since reset
//   auto_on, frozen     mode flags
//   busy                candidate search in progress
module jtframe_debug_viewsel
  import jtframe_debug_viewsel_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lvbl,
  input  logic              key_next,
  input  logic              key_prev,
  input  logic              key_auto,
  input  logic              key_freeze,
  input  logic [NSRC-1:0]   src_req,
  input  logic [8*NSRC-1:0] src_data,
  output logic [2:0]        view_sel,
  output logic [7:0]        view_data,
  output logic              view_valid,
  output logic              auto_on,
  output logic              frozen,
  output logic              busy
);

  localparam logic [2:0] IDX_LAST  = 3'(NSRC - 1);
  localparam logic [2:0] STEP_LAST = 3'(NSRC - 2);
  localparam logic [7:0] CNT_LAST  = 8'(FRAMES - 1);

  // Edge events for the four keys and the lvbl fall
  logic [EV_W-1:0] ev;

  jtframe_debug_edge #(
    .W         (EV_W),
    .FALL_MASK (5'b10000)
  ) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({lvbl, key_freeze, key_auto, key_prev, key_next}),
    .ev    (ev)
  );

  // Pad the source buses to the maximum width so a 3-bit index is always legal
  logic [MAX_NSRC-1:0] req_pad;
  logic [7:0]          data_arr [MAX_NSRC];

  generate
    for (genvar gi = 0; gi < MAX_NSRC; gi++) begin : g_src
      if (gi < NSRC) begin : g_used
        assign req_pad[gi]  = src_req[gi];
        assign data_arr[gi] = src_data[8*gi +: 8];
      end else begin : g_pad
        assign req_pad[gi]  = 1'b0;
        assign data_arr[gi] = 8'd0;
      end
    end
  endgenerate

  state_t     state_reg;
  dir_t       dir_reg;
  logic [2:0] sel_reg, cand_reg, step_reg;
  logic [7:0] frame_cnt_reg, view_data_reg;
  logic       view_valid_reg, auto_on_reg, frozen_reg;

  logic next_ev, prev_ev, auto_ev, freeze_ev, tick;
  assign next_ev   = ev[EV_NEXT];
  assign prev_ev   = ev[EV_PREV];
  assign auto_ev   = ev[EV_AUTO];
  assign freeze_ev = ev[EV_FREEZE];
  assign tick      = ev[EV_LVBL];

  logic idle, manual_go, cnt_wrap, auto_go;
  dir_t start_dir;

  always_comb begin
    idle      = (state_reg == ST_IDLE);
    // Simultaneous next+prev cancel each other out
    manual_go = idle & (next_ev ^ prev_ev);
    cnt_wrap  = auto_on_reg & tick & (frame_cnt_reg == CNT_LAST);
    // Any manual key activity or a running search swallows the auto advance
    auto_go   = cnt_wrap & idle & ~next_ev & ~prev_ev;
    start_dir = (prev_ev & ~next_ev) ? DIR_DOWN : DIR_UP;
  end

  // Selection FSM: one candidate tested per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      dir_reg   <= DIR_UP;
      sel_reg   <= 3'd0;
      cand_reg  <= 3'd0;
      step_reg  <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (manual_go || auto_go) begin
            dir_reg   <= start_dir;
            cand_reg  <= step_idx(sel_reg, start_dir, IDX_LAST);
            step_reg  <= 3'd0;
            state_reg <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (req_pad[cand_reg]) begin
            sel_reg   <= cand_reg;
            state_reg <= ST_IDLE;
          end else if (step_reg == STEP_LAST) begin
            // Every other source declined: keep the current selection
            state_reg <= ST_IDLE;
          end else begin
            cand_reg <= step_idx(cand_reg, dir_reg, IDX_LAST);
            step_reg <= step_reg + 3'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Auto-scan mode and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_on_reg   <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else if (auto_ev) begin
      auto_on_reg   <= ~auto_on_reg;
      frame_cnt_reg <= 8'd0;
    end else if (manual_go) begin
      frame_cnt_reg <= 8'd0;
    end else if (tick && auto_on_reg) begin
      frame_cnt_reg <= cnt_wrap ? 8'd0 : frame_cnt_reg + 8'd1;
    end
  end

  // Freeze flag and once-per-frame latch of the selected source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frozen_reg     <= 1'b0;
      view_data_reg  <= 8'd0;
      view_valid_reg <= 1'b0;
    end else begin
      if (freeze_ev) frozen_reg <= ~frozen_reg;
      // src_req does not gate this: the overlay shows whatever sel points at
      if (tick && !frozen_reg) begin
        view_data_reg  <= data_arr[sel_reg];
        view_valid_reg <= 1'b1;
      end
    end
  end

  assign view_sel   = sel_reg;
  assign view_data  = view_data_reg;
  assign view_valid = view_valid_reg;
  assign auto_on    = auto_on_reg;
  assign frozen     = frozen_reg;
  assign busy       = (state_reg == ST_SEARCH);

endmodule

// File: tb/tb_jtframe_debug_viewsel.sv
module tb_jtframe_debug_viewsel;

  localparam int NSRC   = 4;
  localparam int FRAMES = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lvbl = 1'b1;
  logic              key_next = 1'b0, key_prev = 1'b0, key_auto = 1'b0, key_freeze = 1'b0;
  logic [NSRC-1:0]   src_req = '0;
  logic [8*NSRC-1:0] src_data = '0;
  logic [2:0]        view_sel;
  logic [7:0]        view_data;
  logic              view_valid, auto_on, frozen, busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int       m_sel, m_cnt;
  logic [7:0] m_data;
  bit       m_valid, m_auto, m_frozen;

  always #5 clk = ~clk;

  jtframe_debug_viewsel #(.NSRC(NSRC), .FRAMES(FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .lvbl(lvbl),
    .key_next(key_next), .key_prev(key_prev), .key_auto(key_auto), .key_freeze(key_freeze),
    .src_req(src_req), .src_data(src_data),
    .view_sel(view_sel), .view_data(view_data), .view_valid(view_valid),
    .auto_on(auto_on), .frozen(frozen), .busy(busy)
  );

  // Nearest requesting source in the given direction, excluding the start.
  // lat = number of candidates examined.
  function automatic void msearch(input int sel, input bit up, input logic [NSRC-1:0] req,
                                  output int ns, output int lat);
    ns  = sel;
    lat = NSRC - 1;
    for (int i = 1; i < NSRC; i++) begin
      int c;
      c = up ? (sel + i) % NSRC : (sel - i + NSRC) % NSRC;
      if (req[c]) begin
        ns  = c;
        lat = i;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    m_sel = 0; m_cnt = 0; m_data = 8'd0; m_valid = 0; m_auto = 0; m_frozen = 0;
  endtask

  task automatic model_tick(input bit with_next);
    int ns, lat;
    if (!m_frozen) begin
      m_data  = src_data[8*m_sel +: 8];
      m_valid = 1;
    end
    if (with_next) begin
      msearch(m_sel, 1'b1, src_req, ns, lat);
      m_sel = ns;
      m_cnt = 0;
    end else if (m_auto) begin
      m_cnt++;
      if (m_cnt == FRAMES) begin
        m_cnt = 0;
        msearch(m_sel, 1'b1, src_req, ns, lat);
        m_sel = ns;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  // which: 0 next, 1 prev, 2 both. Key held for 'hold' cycles.
  task automatic press(input int which, input int hold, output int busy_cycles, output bit first_busy);
    @(negedge clk);
    key_next = (which != 1);
    key_prev = (which != 0);
    busy_cycles = 0;
    first_busy  = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) first_busy = busy;
      if (c + 1 >= hold) begin key_next = 1'b0; key_prev = 1'b0; end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic pulse_auto();
    @(negedge clk) key_auto = 1'b1;
    @(negedge clk) key_auto = 1'b0;
    m_auto = !m_auto; m_cnt = 0;
  endtask

  task automatic pulse_freeze();
    @(negedge clk) key_freeze = 1'b1;
    @(negedge clk) key_freeze = 1'b0;
    m_frozen = !m_frozen;
  endtask

  task automatic frame_tick(input bit with_next);
    @(negedge clk) begin lvbl = 1'b0; key_next = with_next; end
    @(negedge clk) begin lvbl = 1'b1; key_next = 1'b0; end
    repeat (5) @(negedge clk);
    model_tick(with_next);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (view_sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", view_sel); end
    checks++; if (view_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%h exp=00", view_data); end
    checks++; if (view_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", view_valid); end
    checks++; if (auto_on !== 1'b0) begin failures++; $display("FAIL reset_auto got=%b exp=0", auto_on); end
    checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    src_req  = 4'b1111;
    src_data = 32'h44332211;
    frame_tick(1'b0);
    checks++; if (view_sel !== 3'd0) begin failures++; $display("FAIL first_latch_sel got=%0d exp=0", view_sel); end
    checks++; if (view_data !== 8'h11) begin failures++; $display("FAIL first_latch_data got=%h exp=11", view_data); end
    checks++; if (view_valid !== 1'b1) begin failures++; $display("FAIL first_latch_valid got=%b exp=1", view_valid); end
    $display("test_reset: sel=%0d data=%h valid=%b", view_sel, view_data, view_valid);
  endtask

  task automatic test_directed_search();
    int         ops [6];
    logic [3:0] reqs [6];
    int ns, lat, bc;
    bit fb;
    ops  = '{0, 0, 0, 1, 1, 0};
    reqs = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      src_req = reqs[i];
      msearch(m_sel, ops[i] == 0, src_req, ns, lat);
      press(ops[i], 1, bc, fb);
      m_sel = ns;
      checks++; if (fb !== 1'b1) begin failures++; $display("FAIL dir_busy_rise op%0d got=%b exp=1", i, fb); end
      checks++; if (bc != lat) begin failures++; $display("FAIL dir_latency op%0d got=%0d exp=%0d", i, bc, lat); end
      checks++; if (view_sel !== 3'(m_sel)) begin failures++; $display("FAIL dir_sel op%0d got=%0d exp=%0d", i, view_sel, m_sel); end
      $display("directed op%0d %s req=%b sel=%0d busy_cycles=%0d", i, ops[i] == 0 ? "next" : "prev", src_req, view_sel, bc);
    end
  endtask

  task automatic test_random_search();
    int ns, lat, bc, op, hold;
    bit fb;
    for (int i = 0; i < 24; i++) begin
      src_req  = NSRC'($urandom_range(0, 15));
      src_data = $urandom;
      op   = $urandom_range(0, 1);
      hold = $urandom_range(1, 6);
      msearch(m_sel, op == 0, src_req, ns, lat);
      press(op, hold, bc, fb);
      m_sel = ns;
      checks++; if (bc != lat) begin failures++; $display("FAIL rnd_latency it%0d got=%0d exp=%0d", i, bc, lat); end
      checks++; if (view_sel !== 3'(m_sel)) begin failures++; $display("FAIL rnd_sel it%0d got=%0d exp=%0d", i, view_sel, m_sel); end
      frame_tick(1'b0);
      checks++; if (view_data !== m_data) begin failures++; $display("FAIL rnd_data it%0d got=%h exp=%h", i, view_data, m_data); end
      $display("random it%0d op=%0d hold=%0d req=%b sel=%0d data=%h", i, op, hold, src_req, view_sel, view_data);
    end
  endtask

  task automatic test_auto();
    do_reset();
    src_req = 4'b1111;
    pulse_auto();
    @(negedge clk);
    checks++; if (auto_on !== 1'b1) begin failures++; $display("FAIL auto_on got=%b exp=1", auto_on); end
    for (int t = 1; t <= 10; t++) begin
      src_data = $urandom;
      frame_tick(t == 6);
      checks++; if (view_sel !== 3'(m_sel)) begin failures++; $display("FAIL auto_sel tick%0d got=%0d exp=%0d", t, view_sel, m_sel); end
      checks++; if (view_data !== m_data) begin failures++; $display("FAIL auto_data tick%0d got=%h exp=%h", t, view_data, m_data); end
      $display("auto tick%0d next=%0d sel=%0d data=%h", t, t == 6, view_sel, view_data);
    end
    pulse_auto();
    @(negedge clk);
    checks++; if (auto_on !== 1'b0) begin failures++; $display("FAIL auto_off got=%b exp=0", auto_on); end
    for (int t = 0; t < 4; t++) begin
      frame_tick(1'b0);
      checks++; if (view_sel !== 3'(m_sel)) begin failures++; $display("FAIL auto_off_sel tick%0d got=%0d exp=%0d", t, view_sel, m_sel); end
    end
    $display("auto off sel=%0d", view_sel);
  endtask

  task automatic test_freeze();
    src_data = $urandom;
    frame_tick(1'b0);
    pulse_freeze();
    @(negedge clk);
    checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL freeze_on got=%b exp=1", frozen); end
    src_data = ~src_data;
    for (int t = 0; t < 2; t++) begin
      frame_tick(1'b0);
      checks++; if (view_data !== m_data) begin failures++; $display("FAIL frozen_data tick%0d got=%h exp=%h", t, view_data, m_data); end
    end
    pulse_freeze();
    @(negedge clk);
    checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL freeze_off got=%b exp=0", frozen); end
    frame_tick(1'b0);
    checks++; if (view_data !== m_data) begin failures++; $display("FAIL unfrozen_data got=%h exp=%h", view_data, m_data); end
    $display("freeze sel=%0d data=%h", view_sel, view_data);
  endtask

  task automatic test_both_keys();
    int bc;
    bit fb;
    src_req = 4'b1111;
    press(2, 1, bc, fb);
    checks++; if (bc != 0) begin failures++; $display("FAIL both_keys_busy got=%0d exp=0", bc); end
    checks++; if (view_sel !== 3'(m_sel)) begin failures++; $display("FAIL both_keys_sel got=%0d exp=%0d", view_sel, m_sel); end
    $display("both keys busy_cycles=%0d sel=%0d", bc, view_sel);
  endtask

  task automatic test_reset_mid_search();
    int ns, lat, bc;
    bit fb;
    src_req = 4'b0100;
    msearch(m_sel, 1'b1, src_req, ns, lat);
    press(0, 1, bc, fb);
    m_sel = ns;
    pulse_auto();
    pulse_freeze();
    frame_tick(1'b0);
    checks++; if (view_sel !== 3'd2) begin failures++; $display("FAIL pre_reset_sel got=%0d exp=2", view_sel); end
    src_req = 4'b0000;
    @(negedge clk) key_next = 1'b1;
    @(negedge clk) key_next = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_search_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({view_sel, view_data, view_valid, auto_on, frozen, busy} !== 15'd0)
      begin failures++; $display("FAIL mid_reset sel=%0d data=%h valid=%b auto=%b frozen=%b busy=%b exp all 0",
                                  view_sel, view_data, view_valid, auto_on, frozen, busy); end
    rst_n = 1'b1;
    model_reset();
    $display("reset mid search sel=%0d busy=%b", view_sel, busy);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed_search();
    test_random_search();
    test_auto();
    test_freeze();
    test_both_keys();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
